four_one_arb: RTL and testbench
===============================

# four_one_arb

Round-robin arbiter and sequencer that shares the 4:1 one-bit multiplexer between four requesters. It grants one requester at a time and drives the mux select. It registers the selected data bit with a valid flag, and it bounds each grant to a programmable number of cycles. The block sits directly in front of `four_one`: its `sel` drives the mux select and its `din` feeds the mux inputs.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles in one grant; legal range 1..255.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: request per requester; held high while the requester wants the mux.
- `din` input 4: data bit per requester, mux input `din[i]`.
- `gnt` output 4: one-hot grant; all zero when idle.
- `sel` output 2: mux select, equal to the encoded index of `gnt`; holds its last value when idle.
- `y` output 1: registered `din[sel]` sampled during grant.
- `valid` output 1: high when `y` carries a granted sample.

## Operation
- Two states: IDLE and GRANT. The registered state is `state`; `ptr` is the last-granted index (2 bits); `cnt` is the hold counter, 8 bits.
- IDLE, with `req != 0`:
  - Pick the first set `req` in search order `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4).
  - Load `gnt`/`sel` with the winner, `ptr` with the winner, `cnt` to 0, then go to GRANT.
- IDLE, with `req == 0`: stay in IDLE, `gnt` = 0.
- GRANT, release when `req[sel]` = 0 or `cnt == MAX_HOLD-1`:
  - Go to IDLE and clear `gnt`.
  - The next grant can appear no earlier than one edge later, so there is a mandatory one-cycle dead gap.
- GRANT, otherwise: `cnt` += 1 and the grant is held.
- Data path, every edge:
  - `valid` <= (state == GRANT).
  - `y` <= `din[sel]` when state == GRANT, else `y` holds.
- Fairness: `ptr` moves only on a new grant. A requester still asserting after a `MAX_HOLD` expiry competes again and has lowest priority.
- Request changes on non-granted lines during GRANT are ignored until the next IDLE.
- `MAX_HOLD` = 1: every grant lasts exactly one cycle, alternating with IDLE.

## Timing
- Reset values: state IDLE, `gnt` 4'b0000, `sel` 2'b00, `ptr` 2'b11 (so requester 0 has first priority), `cnt` 0, `y` 0, `valid` 0.
- Reset acts asynchronously and immediately, including mid-grant. No grant survives reset.
- Grant latency: `req` high before edge k while in IDLE gives `gnt` high after edge k.
- Data latency: `y`/`valid` lag `gnt` by one edge. `din[sel]` sampled at edge k+1 appears after edge k+1.
- A grant lasts at most `MAX_HOLD` cycles: `gnt` is high for edges k..k+MAX_HOLD-1, then low for at least one cycle.
- Early release: `req[sel]` low before edge m causes `gnt` = 0 after edge m.
- Simultaneous requests in IDLE resolve strictly in round-robin order. There are no ties.
- Counter never wraps: release occurs at `MAX_HOLD-1`, which is at most 254.

## Structure
- Shared package `four_one_pkg` holds:
  - state encodings `ST_IDLE` = 1'b0, `ST_GRANT` = 1'b1;
  - `PTR_RST` = 2'b11;
  - `CNT_W` = 8.
- Sub-module `rr_pick4`: combinational. Inputs are `req[3:0]` and `ptr[1:0]`. Outputs are `any` and `idx[1:0]`.
- The top level holds the FSM, counter, grant/select registers and output data register. The mux itself is not instantiated inside; `four_one` is wired alongside at the next level up.

## Test plan
- Reset then single request: `req`=4'b0100 held.
  - Required: `gnt`=4'b0100 and `sel`=2'b10 one edge later.
  - Required: `gnt` drops after 4 cycles, one IDLE cycle, then re-granted to 2.
- Round-robin: `req`=4'b1111 held, `MAX_HOLD`=4.
  - Required grant order is 0,1,2,3,0.
  - Each grant lasts 4 cycles with one gap cycle.
- Early release: grant to requester 1, drop `req[1]` at its 2nd grant cycle.
  - Required: `gnt`=0 after that edge and `cnt` discarded.
  - Required: next pending requester 2 granted one edge later.
- Data path: grant to 3 with `din`=4'b1000, then `din`=4'b0000 next cycle.
  - Required: `y`=1, `valid`=1 one edge after the grant.
  - Required: `y`=0 on the following edge, `valid`=0 one edge after `gnt` drops.
- Async reset mid-grant: assert `rst` between edges during the grant to requester 2.
  - Required: `gnt`, `sel`, `y`, `valid` = 0 immediately, without waiting for an edge.
  - Required: after release with `req`=4'b1111, first grant goes to 0.
- `MAX_HOLD`=1 with `req`=4'b0011.
  - Required: `gnt` sequence 0001, 0000, 0010, 0000, 0001.

Source files
------------

// File: rtl/four_one_pkg.sv
// Shared definitions for the four_one round-robin arbiter slice:
// FSM state encoding, pointer reset value, hold counter width and
// a small index-to-one-hot helper.
package four_one_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Last-granted pointer at reset; requester 0 is searched first.
    localparam logic [1:0] PTR_RST = 2'b11;

    // Hold counter width; MAX_HOLD-1 must fit, so MAX_HOLD <= 255.
    localparam int CNT_W = 8;

    // Convert a 2-bit requester index into a one-hot grant vector.
    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/four_one_arb_if.sv
// Bus between the four requesters and the arbiter: requests and data
// bits flow in, one-hot grant, mux select and the registered sample
// flow back out.
interface four_one_arb_if;

    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       valid;

    // Requester side drives requests and data, observes the arbiter.
    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  y,
        input  valid
    );

    // Arbiter side consumes requests and data, produces grant and sample.
    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output y,
        output valid
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters. Searches
// ptr+1, ptr+2, ptr+3, ptr (mod 4) and reports the first set request.
// When nothing is requested, idx falls back to ptr and any is low.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] w_cand;
    logic       w_found;

    // Walk the rotated priority order; the first hit wins.
    always_comb begin
        any     = |req;
        idx     = ptr;
        w_cand  = ptr;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = ptr + 2'(k);
            if (!w_found && req[w_cand]) begin
                idx     = w_cand;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/four_one_arb.sv
// Round-robin arbiter and sequencer in front of the four_one 4:1 mux.
// Grants one requester at a time, drives the mux select, bounds each
// grant to MAX_HOLD cycles with a forced one-cycle idle gap, and
// registers the selected data bit with a valid flag.
module four_one_arb
    import four_one_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    four_one_arb_if.slave arb_if
);

    // Final count value of a grant; release happens when it is reached.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_y;
    logic             r_valid;

    state_t           w_state_nxt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_any;
    logic [1:0]       w_idx;

    rr_pick4 u_pick (
        .req (arb_if.req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // Control state register; reset clears any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'b00;
            r_ptr   <= PTR_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: pick a winner in IDLE, hold or release in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = 4'b0000;
                if (w_any) begin
                    w_gnt_nxt   = idx_to_onehot(w_idx);
                    w_sel_nxt   = w_idx;
                    w_ptr_nxt   = w_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Release always passes through IDLE, which produces the
                // mandatory dead cycle; sel keeps its last value there.
                if (!arb_if.req[r_sel] || (r_cnt == CNT_LAST)) begin
                    w_gnt_nxt   = 4'b0000;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_gnt_nxt   = 4'b0000;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output sample register: capture din[sel] each granted cycle, lagging gnt by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_GRANT);
            if (r_state == ST_GRANT) begin
                r_y <= arb_if.din[r_sel];
            end
        end
    end

    assign arb_if.gnt   = r_gnt;
    assign arb_if.sel   = r_sel;
    assign arb_if.y     = r_y;
    assign arb_if.valid = r_valid;

endmodule

// File: tb/tb_four_one_arb.sv
// Bench for four_one_arb: two instances (MAX_HOLD 4 and 1) driven with
// directed vectors, checked every cycle against a behavioural model and
// at key points against hand-computed literals.
module tb_four_one_arb;

    logic clk;
    logic rst;

    four_one_arb_if if_a ();
    four_one_arb_if if_b ();

    four_one_arb #(.MAX_HOLD(4)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .arb_if (if_a.slave)
    );

    four_one_arb #(.MAX_HOLD(1)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .arb_if (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: per unit, who owns the mux, how many granted
    // cycles have been used, and who was granted last.
    int   m_hold  [2] = '{4, 1};
    bit   m_busy  [2] = '{0, 0};
    int   m_owner [2] = '{0, 0};
    int   m_last  [2] = '{3, 3};
    int   m_used  [2] = '{0, 0};
    logic m_y     [2] = '{1'b0, 1'b0};
    logic m_valid [2] = '{1'b0, 1'b0};

    task automatic model_reset(input int u);
        m_busy[u]  = 0;
        m_owner[u] = 0;
        m_last[u]  = 3;
        m_used[u]  = 0;
        m_y[u]     = 1'b0;
        m_valid[u] = 1'b0;
    endtask

    task automatic model_step(input int u, input logic [3:0] r, input logic [3:0] d);
        bit found;
        m_valid[u] = m_busy[u];
        if (m_busy[u]) m_y[u] = d[m_owner[u]];
        if (!m_busy[u]) begin
            found = 0;
            for (int i = 1; i <= 4; i++) begin
                if (!found && r[(m_last[u] + i) % 4]) begin
                    found      = 1;
                    m_owner[u] = (m_last[u] + i) % 4;
                end
            end
            if (found) begin
                m_last[u] = m_owner[u];
                m_busy[u] = 1;
                m_used[u] = 1;
            end
        end else if (!r[m_owner[u]] || m_used[u] == m_hold[u]) begin
            m_busy[u] = 0;
        end else begin
            m_used[u]++;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, if_a.req, if_a.din);
            model_step(1, if_b.req, if_b.din);
        end
    end

    function automatic logic [3:0] exp_gnt(input int u);
        return m_busy[u] ? (4'b0001 << m_owner[u]) : 4'b0000;
    endfunction

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("model gnt A",   8'(if_a.gnt),   8'(exp_gnt(0)));
        chk("model sel A",   8'(if_a.sel),   8'(m_owner[0]));
        chk("model y A",     8'(if_a.y),     8'(m_y[0]));
        chk("model valid A", 8'(if_a.valid), 8'(m_valid[0]));
        chk("model gnt B",   8'(if_b.gnt),   8'(exp_gnt(1)));
        chk("model sel B",   8'(if_b.sel),   8'(m_owner[1]));
        chk("model y B",     8'(if_b.y),     8'(m_y[1]));
        chk("model valid B", 8'(if_b.valid), 8'(m_valid[1]));
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    logic [3:0] single_seq [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    logic [3:0] hold1_seq  [5] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};

    initial begin
        rst      = 1'b1;
        if_a.req = 4'b0000;
        if_a.din = 4'b0000;
        if_b.req = 4'b0000;
        if_b.din = 4'b0101;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst gnt",   8'(if_a.gnt),   8'h00);
        chk("rst sel",   8'(if_a.sel),   8'h00);
        chk("rst y",     8'(if_a.y),     8'h00);
        chk("rst valid", 8'(if_a.valid), 8'h00);

        // Single request on A, MAX_HOLD=1 pattern on B
        if_a.req = 4'b0100;
        if_b.req = 4'b0011;
        rst      = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("single gnt", 8'(if_a.gnt), 8'(single_seq[c]));
            if (c < 5) chk("hold1 gnt", 8'(if_b.gnt), 8'(hold1_seq[c]));
            if (c == 0) chk("single sel", 8'(if_a.sel), 8'h02);
        end
        if_a.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Round robin with all requesting after reset: 0,1,2,3,0
        pulse_reset();
        if_a.req = 4'b1111;
        rst      = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            chk("rr gnt", 8'(if_a.gnt),
                8'(((c % 5) < 4) ? (4'b0001 << ((c / 5) % 4)) : 4'b0000));
        end
        if_a.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Early release of requester 1, then pending requester 2
        pulse_reset();
        if_a.req = 4'b0110;
        rst      = 1'b0;
        @(negedge clk);
        chk("early gnt1 c1", 8'(if_a.gnt), 8'h02);
        @(negedge clk);
        chk("early gnt1 c2", 8'(if_a.gnt), 8'h02);
        if_a.req = 4'b0100;
        @(negedge clk);
        chk("early drop", 8'(if_a.gnt), 8'h00);
        @(negedge clk);
        chk("early next gnt", 8'(if_a.gnt), 8'h04);
        chk("early next sel", 8'(if_a.sel), 8'h02);
        if_a.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Data path through requester 3
        pulse_reset();
        if_a.req = 4'b1000;
        if_a.din = 4'b1000;
        rst      = 1'b0;
        @(negedge clk);
        chk("dp gnt", 8'(if_a.gnt), 8'h08);
        chk("dp valid0", 8'(if_a.valid), 8'h00);
        @(negedge clk);
        chk("dp y1", 8'(if_a.y), 8'h01);
        chk("dp valid1", 8'(if_a.valid), 8'h01);
        if_a.din = 4'b0000;
        if_a.req = 4'b0000;
        @(negedge clk);
        chk("dp y0", 8'(if_a.y), 8'h00);
        chk("dp gnt off", 8'(if_a.gnt), 8'h00);
        chk("dp valid last", 8'(if_a.valid), 8'h01);
        @(negedge clk);
        chk("dp valid off", 8'(if_a.valid), 8'h00);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a grant to requester 2
        pulse_reset();
        if_a.req = 4'b0100;
        if_a.din = 4'b0100;
        rst      = 1'b0;
        @(negedge clk);
        chk("ar gnt", 8'(if_a.gnt), 8'h04);
        @(negedge clk);
        chk("ar y pre", 8'(if_a.y), 8'h01);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar gnt now",   8'(if_a.gnt),   8'h00);
        chk("ar sel now",   8'(if_a.sel),   8'h00);
        chk("ar y now",     8'(if_a.y),     8'h00);
        chk("ar valid now", 8'(if_a.valid), 8'h00);
        @(negedge clk);
        if_a.req = 4'b1111;
        rst      = 1'b0;
        @(negedge clk);
        chk("ar first gnt", 8'(if_a.gnt), 8'h01);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
